seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a common multi-digit 7-segment display.
- Holds a frame of NUM_DIGITS BCD digits and steps through them one at a time. Each digit is decoded to segments and its digit enable is driven, with a blanking guard between digits to prevent ghosting.
- New frames are accepted through a valid/ready handshake and applied only at frame boundaries, so the display never shows a mix of two frames.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 34 +++
 rtl/seg7_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : shared widths, segment encodings and slot phase type
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  // Segment order {a,b,c,d,e,f,g}, a = bit 6, active-high
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : combinational BCD digit to 7-segment decoder
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [SEG_W-1:0] seg
);

  // Codes 10..15 render as blank rather than hex glyphs
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// seg7_scan_ctrl : multiplexed 7-segment scan controller with frame-atomic load
//                  optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros
// Revision       : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_tick
);

  localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = BCD_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [FRAME_W-1:0]    r_disp;
  logic [FRAME_W-1:0]    r_pend;
  logic                  r_pend_full;

  phase_e                w_phase;
  logic                  w_slot_end;
  logic                  w_boundary;
  logic                  w_accept;
  logic [BCD_W-1:0]      w_digits [NUM_DIGITS];
  logic [BCD_W-1:0]      w_digit;
  logic [SEG_W-1:0]      w_dec_seg;
  logic                  w_digit_blank;
  logic [NUM_DIGITS-1:0] w_onehot;

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign w_digits[g] = r_disp[g*BCD_W +: BCD_W];
    end

    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_phase = PH_DRIVE;
    end else begin : g_blank
      assign w_phase = (r_cnt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
    end
  endgenerate

  assign w_digit    = w_digits[r_idx];
  assign w_onehot   = NUM_DIGITS'(1) << r_idx;
  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);
  assign w_accept   = load_valid && !r_pend_full;
  assign load_ready = !r_pend_full;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_zero_run;

  // Walk down from the top digit; digit 0 always stays visible
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_run = w_zero_run && (w_digits[k] == '0);
      w_lz[k]    = w_zero_run;
    end
  end

  assign w_digit_blank = w_lz[r_idx];
`else
  assign w_digit_blank = 1'b0;
`endif

  seg7_decode u_decode (
    .digit (w_digit),
    .seg   (w_dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Display only changes at a frame boundary, so a frame is never torn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp      <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else if (w_boundary && r_pend_full) begin
      r_disp      <= r_pend;
      r_pend_full <= 1'b0;
    end else if (w_boundary && w_accept) begin
      r_disp      <= bcd_in;
    end else if (w_accept) begin
      r_pend      <= bcd_in;
      r_pend_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      an         <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_boundary;
      if (w_phase == PH_DRIVE) begin
        an  <= w_onehot;
        seg <= w_digit_blank ? SEG_BLANK : w_dec_seg;
      end else begin
        an  <= '0;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// tb_seg7_scan_ctrl : directed self-checking bench, 4 digits, 4-cycle slots, 1 blank
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] bcd_in = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;

  logic [15:0] exp_disp = '0;
  logic [15:0] exp_next = '0;
  bit          exp_swap = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .bcd_in     (bcd_in),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (k=%0d): observed %0h required %0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int slot);
    logic [3:0] d;
    d = exp_disp[slot*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (slot != 0 && (exp_disp >> (4*slot)) == 16'h0) return 7'b0000000;
`endif
    return seg_tab[d];
  endfunction

  // Step n clocks; k counts rising edges since reset release
  task automatic run(input int n);
    int p, slot, c;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      p     = (k - 1) % 16;
      slot  = p / 4;
      c     = p % 4;
      e_an  = (c < BC) ? 4'b0000 : 4'(1 << slot);
      e_seg = (c < BC) ? 7'b0000000 : digit_seg(slot);
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("frame_tick", 32'(frame_tick), 32'((k % 16) == 0));
      if ((k % 16) == 0 && exp_swap) begin
        exp_disp = exp_next;
        exp_swap = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    check("rst_ready", 32'(load_ready), 32'h1);
    rst = 1'b0;
    k   = 0;

    // Idle scan of zeros, then a mid-frame load
    run(34);
    check("ready_idle", 32'(load_ready), 32'h1);
    load_valid = 1'b1;
    bcd_in     = 16'h1234;
    exp_next   = 16'h1234;
    exp_swap   = 1'b1;
    run(1);
    check("ready_after_accept", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    bcd_in     = 16'hFFFF;
    run(13);
    check("ready_after_boundary", 32'(load_ready), 32'h1);

    // Accept in the boundary cycle goes straight to the display
    run(15);
    load_valid = 1'b1;
    bcd_in     = 16'h5678;
    exp_next   = 16'h5678;
    exp_swap   = 1'b1;
    run(1);
    check("ready_boundary_direct", 32'(load_ready), 32'h1);
    load_valid = 1'b0;

    // Second load in the same frame, digit 2 = 0xC shows blank
    run(2);
    load_valid = 1'b1;
    bcd_in     = 16'h9C01;
    run(1);
    check("ready_second_load", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    exp_next   = 16'h9C01;
    exp_swap   = 1'b1;
    run(31);

    // Fill pending, then reset while digit 2 is driven
    load_valid = 1'b1;
    bcd_in     = 16'h4321;
    run(1);
    check("ready_pend_full", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    run(7);
    check("an_before_rst", 32'(an), 32'h4);
    rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'h0);
    check("async_rst_seg", 32'(seg), 32'h0);
    check("async_rst_ready", 32'(load_ready), 32'h1);
    check("async_rst_tick", 32'(frame_tick), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("held_rst_an", 32'(an), 32'h0);
    rst      = 1'b0;
    k        = 0;
    exp_disp = 16'h0000;
    exp_swap = 1'b0;
    run(34);

    // Leading-zero case
    load_valid = 1'b1;
    bcd_in     = 16'h0070;
    exp_next   = 16'h0070;
    exp_swap   = 1'b1;
    run(1);
    load_valid = 1'b0;
    run(29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
